// File: rtl/mem_port_arb_pkg.sv
// Shared types for mem_port_arb: FSM states, transaction owner ids and the
// width of the fetch-starvation counter.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FE = 1'b0,
    OWN_DA = 1'b1
  } owner_e;

  // Wide enough for FAIR_MAX up to 15.
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arb_pick.sv
// Winner select for the shared memory port: data has priority, but fetch is
// forced through after FAIR_MAX consecutive data wins while it was waiting.
module mem_port_arb_pick
  import mem_port_arb_pkg::*;
#(
  parameter int FAIR_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   arb_en,
  input  logic   fe_req,
  input  logic   da_req,
  output owner_e winner
);

  localparam logic [STARVE_W-1:0] FAIR_LIM = STARVE_W'(FAIR_MAX);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    winner = (fe_req && (!da_req || starve_cnt_q == FAIR_LIM)) ? OWN_FE : OWN_DA;
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (arb_en && (fe_req || da_req)) begin
      if (winner == OWN_FE)
        starve_cnt_d = '0;
      else if (fe_req && starve_cnt_q != FAIR_LIM)
        starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/mem_port_arb.sv
// Serialises fetch and load/store requests onto one synchronous memory port.
// Optional WAIT-state timeout is built when MEM_PORT_ARB_TIMEOUT_EN is defined.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int FAIR_MAX = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fe_req,
  input  logic [AW-1:0] fe_addr,
  output logic          fe_gnt,
  output logic          fe_rvalid,
  output logic [DW-1:0] fe_rdata,
  output logic          fe_err,
  input  logic            da_req,
  input  logic            da_we,
  input  logic [AW-1:0]   da_addr,
  input  logic [DW-1:0]   da_wdata,
  input  logic [DW/8-1:0] da_be,
  output logic            da_gnt,
  output logic            da_rvalid,
  output logic [DW-1:0]   da_rdata,
  output logic            da_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  state_e            state_q;
  owner_e            owner_q, winner;
  logic              mem_req_q, mem_we_q;
  logic [AW-1:0]     mem_addr_q;
  logic [DW-1:0]     mem_wdata_q;
  logic [DW/8-1:0]   mem_be_q;
  logic              fe_rvalid_q, da_rvalid_q;
  logic [DW-1:0]     fe_rdata_q, da_rdata_q;
  logic              resp_fire;
  logic [DW-1:0]     resp_data;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic              resp_err;
  logic              fe_err_q, da_err_q;
  logic [7:0]        wait_cnt_q;
`endif

  mem_port_arb_pick #(.FAIR_MAX(FAIR_MAX)) u_pick (
    .clk    (clk),
    .rst    (rst),
    .arb_en (state_q == IDLE),
    .fe_req (fe_req),
    .da_req (da_req),
    .winner (winner)
  );

  // A response is either real read data or, with the timeout built, an error.
  always_comb begin
    resp_fire = 1'b0;
    resp_data = mem_rdata;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    resp_err  = 1'b0;
`endif
    if (state_q == WAIT) begin
      if (mem_rvalid) begin
        resp_fire = 1'b1;
      end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
      else if (wait_cnt_q == WAIT_LAST) begin
        resp_fire = 1'b1;
        resp_err  = 1'b1;
        resp_data = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      fe_rvalid_q <= 1'b0;
      da_rvalid_q <= 1'b0;
      fe_rdata_q  <= '0;
      da_rdata_q  <= '0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
      fe_err_q    <= 1'b0;
      da_err_q    <= 1'b0;
      wait_cnt_q  <= '0;
`endif
    end else begin
      fe_rvalid_q <= 1'b0;
      da_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (fe_req || da_req) begin
          owner_q   <= winner;
          mem_req_q <= 1'b1;
          state_q   <= REQ;
          if (winner == OWN_DA) begin
            mem_we_q    <= da_we;
            mem_addr_q  <= da_addr;
            mem_wdata_q <= da_wdata;
            mem_be_q    <= da_be;
          end else begin
            // Fetches are full-word reads.
            mem_we_q    <= 1'b0;
            mem_addr_q  <= fe_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= '1;
          end
        end
        REQ: if (mem_gnt) begin
          mem_req_q <= 1'b0;
          if (mem_we_q) begin
            state_q <= IDLE;
          end else begin
            state_q <= WAIT;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end
        end
        WAIT: if (resp_fire) begin
          state_q <= IDLE;
          if (owner_q == OWN_FE) begin
            fe_rvalid_q <= 1'b1;
            fe_rdata_q  <= resp_data;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            fe_err_q    <= resp_err;
`endif
          end else begin
            da_rvalid_q <= 1'b1;
            da_rdata_q  <= resp_data;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            da_err_q    <= resp_err;
`endif
          end
        end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        else begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fe_gnt    = mem_gnt && (state_q == REQ) && (owner_q == OWN_FE);
  assign da_gnt    = mem_gnt && (state_q == REQ) && (owner_q == OWN_DA);
  assign fe_rvalid = fe_rvalid_q;
  assign da_rvalid = da_rvalid_q;
  assign fe_rdata  = fe_rdata_q;
  assign da_rdata  = da_rdata_q;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
  assign fe_err    = fe_err_q;
  assign da_err    = da_err_q;
`else
  assign fe_err    = 1'b0;
  assign da_err    = 1'b0;
`endif
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed self-checking bench for mem_port_arb: priority, fairness, stalled
// writes, late/spurious read data, optional timeout and mid-transaction reset.
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        fe_req;
  logic [31:0] fe_addr;
  logic        fe_gnt, fe_rvalid, fe_err;
  logic [31:0] fe_rdata;
  logic        da_req, da_we;
  logic [31:0] da_addr, da_wdata;
  logic [3:0]  da_be;
  logic        da_gnt, da_rvalid, da_err;
  logic [31:0] da_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_port_arb #(.AW(32), .DW(32), .FAIR_MAX(4), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst(rst),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_gnt(fe_gnt), .fe_rvalid(fe_rvalid),
    .fe_rdata(fe_rdata), .fe_err(fe_err),
    .da_req(da_req), .da_we(da_we), .da_addr(da_addr), .da_wdata(da_wdata),
    .da_be(da_be), .da_gnt(da_gnt), .da_rvalid(da_rvalid), .da_rdata(da_rdata),
    .da_err(da_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [140:0] all_outs();
    return {fe_gnt, fe_rvalid, fe_rdata, fe_err, da_gnt, da_rvalid, da_rdata, da_err,
            mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    fe_req = 1'b0; fe_addr = '0;
    da_req = 1'b0; da_we = 1'b0; da_addr = '0; da_wdata = '0; da_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outs: got %h want 0", all_outs());
    end
    rst = 1'b0;
    tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL idle_after_reset: got %h want 0", all_outs());
    end
  endtask

  task automatic test_priority();
    fe_req = 1'b1; fe_addr = 32'h0000_0100;
    da_req = 1'b1; da_we = 1'b0; da_addr = 32'h0000_0200; da_be = 4'hF;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, busy} !== {1'b1, 1'b0, 32'h0000_0200, 1'b1}) begin
      errors++; $display("FAIL prio_latch: got req=%b we=%b addr=%h busy=%b want 1 0 00000200 1",
                         mem_req, mem_we, mem_addr, busy);
    end
    mem_gnt = 1'b1; #1;
    checks++;
    if ({da_gnt, fe_gnt} !== 2'b10) begin
      errors++; $display("FAIL prio_gnt: got da_gnt=%b fe_gnt=%b want 1 0", da_gnt, fe_gnt);
    end
    tick();
    da_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({da_rvalid, da_rdata, da_err, fe_rvalid, busy} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL prio_da_resp: got rv=%b data=%h err=%b fe_rv=%b busy=%b want 1 deadbeef 0 0 0",
                         da_rvalid, da_rdata, da_err, fe_rvalid, busy);
    end
    tick();
    checks++;
    if ({mem_req, mem_addr, da_rvalid} !== {1'b1, 32'h0000_0100, 1'b0}) begin
      errors++; $display("FAIL prio_fe_next: got req=%b addr=%h da_rv=%b want 1 00000100 0",
                         mem_req, mem_addr, da_rvalid);
    end
    mem_gnt = 1'b1; #1;
    checks++;
    if ({fe_gnt, da_gnt} !== 2'b10) begin
      errors++; $display("FAIL prio_fe_gnt: got fe_gnt=%b da_gnt=%b want 1 0", fe_gnt, da_gnt);
    end
    tick();
    fe_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({fe_rvalid, fe_rdata, da_rvalid} !== {1'b1, 32'h1234_5678, 1'b0}) begin
      errors++; $display("FAIL prio_fe_resp: got rv=%b data=%h da_rv=%b want 1 12345678 0",
                         fe_rvalid, fe_rdata, da_rvalid);
    end
  endtask

  task automatic test_fairness();
    logic exp_fe;
    logic [31:0] exp_addr;
    fe_req = 1'b1; fe_addr = 32'h0000_0400;
    da_req = 1'b1; da_we = 1'b1; da_addr = 32'h0000_0300; da_wdata = 32'h5555_AAAA; da_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      exp_fe   = (i == 4);
      exp_addr = exp_fe ? 32'h0000_0400 : 32'h0000_0300;
      tick();
      mem_gnt = 1'b1; #1;
      checks++;
      if ({mem_addr, mem_we, fe_gnt, da_gnt} !== {exp_addr, ~exp_fe, exp_fe, ~exp_fe}) begin
        errors++; $display("FAIL fair_arb%0d: got addr=%h we=%b fe_gnt=%b da_gnt=%b want %h %b %b %b",
                           i, mem_addr, mem_we, fe_gnt, da_gnt, exp_addr, ~exp_fe, exp_fe, ~exp_fe);
      end
      tick();
      mem_gnt = 1'b0;
    end
    fe_req = 1'b0; da_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({fe_rvalid, fe_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL fair_fe_resp: got rv=%b data=%h want 1 0badf00d", fe_rvalid, fe_rdata);
    end
    checks++;
    if (u_dut.u_pick.starve_cnt_q !== 4'd0) begin
      errors++; $display("FAIL fair_starve_clear: got %0d want 0", u_dut.u_pick.starve_cnt_q);
    end
  endtask

  task automatic test_write_stall();
    int gnt_seen = 0;
    int rv_seen  = 0;
    int req_cyc  = 0;
    da_req = 1'b1; da_we = 1'b1; da_addr = 32'h0000_0040;
    da_wdata = 32'hCAFE_F00D; da_be = 4'b0011;
    tick();
    for (int c = 0; c < 4; c++) begin
      mem_gnt = (c == 3); #1;
      if (mem_req) req_cyc++;
      if (da_gnt) gnt_seen++;
      checks++;
      if ({mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'b0011}) begin
        errors++; $display("FAIL wr_fields_c%0d: got we=%b addr=%h wdata=%h be=%b want 1 00000040 cafef00d 0011",
                           c, mem_we, mem_addr, mem_wdata, mem_be);
      end
      tick();
    end
    da_req = 1'b0; mem_gnt = 1'b0;
    checks++;
    if ({req_cyc, gnt_seen} !== {32'd4, 32'd1}) begin
      errors++; $display("FAIL wr_req_gnt_count: got req=%0d gnt=%0d want 4 1", req_cyc, gnt_seen);
    end
    for (int c = 0; c < 4; c++) begin
      if (da_rvalid || fe_rvalid) rv_seen++;
      tick();
    end
    checks++;
    if ({rv_seen, mem_req, busy} !== {32'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL wr_no_rvalid: got rv=%0d req=%b busy=%b want 0 0 0", rv_seen, mem_req, busy);
    end
  endtask

  task automatic test_late_read();
    int rv_seen = 0;
    fe_req = 1'b1; fe_addr = 32'h0000_0080;
    tick();
    mem_gnt = 1'b1; #1;
    checks++;
    if (fe_gnt !== 1'b1) begin
      errors++; $display("FAIL late_gnt: got %b want 1", fe_gnt);
    end
    tick();
    fe_req = 1'b0; mem_gnt = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (fe_rvalid || !busy) rv_seen++;
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001;
    tick();
    checks++;
    if ({rv_seen, fe_rvalid, fe_rdata, fe_err, busy} !== {32'd0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0}) begin
      errors++; $display("FAIL late_resp: got early=%0d rv=%b data=%h err=%b busy=%b want 0 1 a5a50001 0 0",
                         rv_seen, fe_rvalid, fe_rdata, fe_err, busy);
    end
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({fe_rvalid, da_rvalid, fe_rdata, busy} !== {1'b0, 1'b0, 32'hA5A5_0001, 1'b0}) begin
      errors++; $display("FAIL spurious_rvalid: got fe_rv=%b da_rv=%b data=%h busy=%b want 0 0 a5a50001 0",
                         fe_rvalid, da_rvalid, fe_rdata, busy);
    end
  endtask

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early = 0;
    fe_req = 1'b1; fe_addr = 32'h0000_0C00;
    tick();
    mem_gnt = 1'b1;
    tick();
    fe_req = 1'b0; mem_gnt = 1'b0;
    for (int c = 0; c < 254; c++) begin
      if (fe_rvalid || !busy) early++;
      tick();
    end
    tick();
    checks++;
    if ({early, fe_rvalid, fe_err, fe_rdata, busy} !== {32'd0, 1'b1, 1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL timeout_resp: got early=%0d rv=%b err=%b data=%h busy=%b want 0 1 1 0 0",
                         early, fe_rvalid, fe_err, fe_rdata, busy);
    end
  endtask
`endif

  task automatic test_reset_in_wait();
    int rv_seen = 0;
    da_req = 1'b1; da_we = 1'b0; da_addr = 32'h0000_0500; da_be = 4'hF;
    tick();
    mem_gnt = 1'b1;
    tick();
    da_req = 1'b0; mem_gnt = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (da_rvalid || !busy) rv_seen++;
      tick();
    end
    checks++;
    if (rv_seen !== 0) begin
      errors++; $display("FAIL wait_holds: got %0d early events want 0", rv_seen);
    end
    rst = 1'b1; #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL rst_in_wait: got %h want 0", all_outs());
    end
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({fe_rvalid, da_rvalid, da_rdata, fe_rdata, busy, mem_req} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL late_rvalid_after_rst: got fe_rv=%b da_rv=%b da_d=%h fe_d=%h busy=%b req=%b want all 0",
                         fe_rvalid, da_rvalid, da_rdata, fe_rdata, busy, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_fairness();
    test_write_stall();
    test_late_read();
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
